// File: rtl/smp_bus_arbiter_if.sv
// Signal bundle of the SMP snooping bus: CPU requests, grants/responses, snoop broadcast and memory port.
// The arbiter connects through the master modport; CPUs and memory sit on the slave side.
interface smp_bus_arbiter_if #(
  parameter int unsigned NUM_CPUS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
);
  localparam int unsigned ID_W = $clog2(NUM_CPUS);

  logic [NUM_CPUS-1:0]        req;
  logic [NUM_CPUS-1:0]        req_rw;
  logic [NUM_CPUS*ADDR_W-1:0] req_addr;
  logic [NUM_CPUS*DATA_W-1:0] req_data;
  logic [NUM_CPUS-1:0]        grant;
  logic [DATA_W-1:0]          resp_data;
  logic                       resp_err;
  logic                       snoop_valid;
  logic                       snoop_rw;
  logic [ADDR_W-1:0]          snoop_addr;
  logic [ID_W-1:0]            snoop_src;
  logic                       mem_req;
  logic                       mem_rw;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic                       mem_ack;
  logic [DATA_W-1:0]          mem_rdata;
  logic                       busy;

  modport master (
    input  req, req_rw, req_addr, req_data, mem_ack, mem_rdata,
    output grant, resp_data, resp_err, snoop_valid, snoop_rw, snoop_addr, snoop_src,
           mem_req, mem_rw, mem_addr, mem_wdata, busy
  );

  modport slave (
    output req, req_rw, req_addr, req_data, mem_ack, mem_rdata,
    input  grant, resp_data, resp_err, snoop_valid, snoop_rw, snoop_addr, snoop_src,
           mem_req, mem_rw, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/smp_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the SMP snooping bus (IDLE -> SNOOP -> MEM -> DONE).
// Define SMP_ARB_TIMEOUT_EN to abort memory waits longer than TIMEOUT cycles with resp_err.
module smp_bus_arbiter #(
  parameter int unsigned NUM_CPUS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  smp_bus_arbiter_if.master bus
);
  localparam int unsigned ID_W = $clog2(NUM_CPUS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    MEM   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ID_W-1:0]     last_q, last_d, win_id;
  logic                any_req, expire;
  logic                win_rw;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  logic [NUM_CPUS-1:0] grant_d;
  logic [DATA_W-1:0]   resp_data_d;
  logic                resp_err_d;
  logic                snoop_valid_d, snoop_rw_d;
  logic [ADDR_W-1:0]   snoop_addr_d;
  logic [ID_W-1:0]     snoop_src_d;
  logic                mem_req_d, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                busy_d;

  // Winner: first requester scanning upward from last+1, wrapping around.
  always_comb begin : arb_pick
    logic [ID_W-1:0] idx;
    idx     = '0;
    win_id  = last_q;
    any_req = 1'b0;
    for (int unsigned off = 1; off <= NUM_CPUS; off++) begin
      idx = ID_W'((32'(last_q) + off) % NUM_CPUS);
      if (!any_req && bus.req[idx]) begin
        any_req = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign win_rw   = bus.req_rw[win_id];
  assign win_addr = bus.req_addr[32'(win_id)*ADDR_W +: ADDR_W];
  assign win_data = bus.req_data[32'(win_id)*DATA_W +: DATA_W];

`ifdef SMP_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts cycles spent in MEM; expiry coincides with the TIMEOUT-th mem_req cycle.
  always_ff @(posedge clk or posedge reset) begin : tmo_counter
    if (reset)              tmo_cnt <= '0;
    else if (state == MEM)  tmo_cnt <= tmo_cnt + CNT_W'(1);
    else                    tmo_cnt <= '0;
  end

  assign expire = (state == MEM) && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign expire         = 1'b0;
`endif

  // State, pointer and output registers; request fields are latched straight into the snoop/mem outputs.
  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      state           <= IDLE;
      last_q          <= ID_W'(NUM_CPUS - 1);
      bus.grant       <= '0;
      bus.resp_data   <= '0;
      bus.resp_err    <= 1'b0;
      bus.snoop_valid <= 1'b0;
      bus.snoop_rw    <= 1'b0;
      bus.snoop_addr  <= '0;
      bus.snoop_src   <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_rw      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= next_state;
      last_q          <= last_d;
      bus.grant       <= grant_d;
      bus.resp_data   <= resp_data_d;
      bus.resp_err    <= resp_err_d;
      bus.snoop_valid <= snoop_valid_d;
      bus.snoop_rw    <= snoop_rw_d;
      bus.snoop_addr  <= snoop_addr_d;
      bus.snoop_src   <= snoop_src_d;
      bus.mem_req     <= mem_req_d;
      bus.mem_rw      <= mem_rw_d;
      bus.mem_addr    <= mem_addr_d;
      bus.mem_wdata   <= mem_wdata_d;
      bus.busy        <= busy_d;
    end
  end

  always_comb begin : fsm_next
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = SNOOP;
      SNOOP:   next_state = MEM;
      MEM:     if (bus.mem_ack || expire) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; mem_ack wins over a same-edge expiry.
  always_comb begin : fsm_out
    grant_d       = '0;
    resp_data_d   = bus.resp_data;
    resp_err_d    = 1'b0;
    snoop_valid_d = 1'b0;
    snoop_rw_d    = bus.snoop_rw;
    snoop_addr_d  = bus.snoop_addr;
    snoop_src_d   = bus.snoop_src;
    mem_req_d     = 1'b0;
    mem_rw_d      = bus.mem_rw;
    mem_addr_d    = bus.mem_addr;
    mem_wdata_d   = bus.mem_wdata;
    busy_d        = (next_state != IDLE);
    last_d        = last_q;
    case (state)
      IDLE: begin
        if (any_req) begin
          snoop_valid_d = 1'b1;
          snoop_rw_d    = win_rw;
          snoop_addr_d  = win_addr;
          snoop_src_d   = win_id;
          mem_rw_d      = win_rw;
          mem_addr_d    = win_addr;
          mem_wdata_d   = win_data;
        end
      end
      SNOOP: mem_req_d = 1'b1;
      MEM: begin
        if (bus.mem_ack) begin
          grant_d     = NUM_CPUS'(1) << bus.snoop_src;
          resp_data_d = bus.mem_rw ? bus.mem_wdata : bus.mem_rdata;
        end else if (expire) begin
          grant_d     = NUM_CPUS'(1) << bus.snoop_src;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
        end else begin
          mem_req_d   = 1'b1;
        end
      end
      DONE: last_d = bus.snoop_src;
      default: ;
    endcase
  end
endmodule

// File: doc/smp_bus_arbiter.md
Name: smp_bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the shared snooping bus of the SMP cache subsystem.
- Accepts miss/write-back requests from NUM_CPUS cache controllers and grants one at a time.
- Broadcasts each winning transaction as a one-cycle snoop so peer caches can invalidate, then runs it against main memory and returns the result with a one-cycle grant.

Parameters:
- NUM_CPUS, 4, number of requesting cache controllers (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, memory-wait cycles before abort (used only with SMP_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_CPUS  per-CPU bus request, level, held until granted
- req_rw  in  NUM_CPUS  per-CPU direction, 1=write, 0=read
- req_addr  in  NUM_CPUS*ADDR_W  per-CPU address, CPU i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_CPUS*DATA_W  per-CPU write data, same packing
- grant  out  NUM_CPUS  one-hot completion pulse to the owning CPU
- resp_data  out  DATA_W  read data (reads) or echoed write data, valid with grant
- resp_err  out  1  timeout abort flag, valid with grant
- snoop_valid  out  1  one-cycle snoop broadcast strobe
- snoop_rw  out  1  direction of the snooped transaction
- snoop_addr  out  ADDR_W  snooped address
- snoop_src  out  $clog2(NUM_CPUS)  owner ID; that CPU ignores its own snoop
- mem_req  out  1  memory request, held until mem_ack
- mem_rw  out  1  memory direction
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0; state=IDLE; last-grant pointer=NUM_CPUS-1 so CPU0 has first priority.
- Registered FSM: IDLE -> SNOOP -> MEM -> DONE -> IDLE.
- IDLE:
  - req sampled only in this state.
  - If any bit is set, the winner is the first set bit scanning upward from (last+1) mod NUM_CPUS, with wrap-around.
  - Latch winner id, addr, rw, data; next state SNOOP.
  - If req==0, stay in IDLE.
- SNOOP: snoop_valid=1 for exactly this cycle, with snoop_rw/addr/src from the latched values; next state MEM.
- MEM:
  - mem_req=1 with latched rw/addr/wdata, stable until the edge where mem_ack=1.
  - On that edge, capture mem_rdata (reads) or latched data (writes) into resp_data; next state DONE.
  - mem_ack outside MEM is ignored.
- DONE:
  - grant[id]=1 and resp_data/resp_err valid for exactly this cycle.
  - last<=id; next state IDLE.
  - After DONE, resp_data holds its value; resp_err clears.
- Requester rule: deassert req in the cycle after grant is seen. The arbiter re-samples req only after one full IDLE cycle, so no double grant occurs.
- Latency:
  - req sampled at edge k gives snoop_valid in cycle k+1 and mem_req from cycle k+2.
  - With mem_ack in the first mem_req cycle, grant is in cycle k+3.
  - Minimum spacing between grants is 4 cycles.
- Simultaneous requests: exactly one winner per arbitration. Losers keep req high and win in later rounds in rotation order. No CPU waits more than NUM_CPUS-1 transactions.
- New requests arriving during SNOOP/MEM/DONE wait for IDLE; req changes mid-transaction do not affect latched values.
- Reset mid-transaction:
  - Immediate abort; all outputs 0 and pointer reset.
  - No grant is issued for the aborted transaction.

Optional Feature:
- SMP_ARB_TIMEOUT_EN defined:
  - A counter runs in MEM. After TIMEOUT cycles without mem_ack, mem_req drops and the FSM goes to DONE.
  - In that DONE cycle: grant[id]=1, resp_err=1, resp_data=0.
  - A mem_ack on the same edge as expiry wins; the transaction completes normally with resp_err=0.
- Undefined: no counter; MEM waits indefinitely; resp_err is tied to 0.

Test Plan:
- Reset then single read: req=4'b0001, req_addr[0]=0x100, mem_ack with mem_rdata=0xDEADBEEF on the first mem_req cycle -> snoop_valid in cycle k+1 (addr 0x100, src 0), grant=0001 in cycle k+3, resp_data=0xDEADBEEF.
- Write from CPU2: req_rw[2]=1, addr 0x200, data 0x12345678 -> snoop_rw=1, snoop_src=2, mem_rw=1, mem_wdata=0x12345678, grant=0100, resp_data=0x12345678.
- Fairness: req=4'b1111 held, each CPU drops req after its grant -> grant order 0001, 0010, 0100, 1000; then CPU0 requests again and is served.
- Wrap-around: last=3, req=4'b1001 -> CPU0 wins; next round CPU3 wins.
- Memory stall plus reset: mem_ack withheld 10 cycles -> mem_req and address stay stable. Then assert reset during MEM -> all outputs 0 next cycle, no grant issued.
- With SMP_ARB_TIMEOUT_EN and TIMEOUT=8, no mem_ack -> mem_req drops after 8 cycles; grant with resp_err=1, resp_data=0. A separate run with mem_ack on the expiry edge -> resp_err=0.
